tcdm_arbiter_nx1: RTL and testbench
===================================

TCDM_ARBITER_NX1 -- requirements
Module: tcdm_arbiter_nx1

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of slave-side TCDM ports (range 1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8); BE_W = DATA_W/8.
REQ-004 SHALL have parameter MAX_OUT, default 2, maximum outstanding granted transactions (range 1..8).
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have slv_req_i  in  NUM_PORTS  per-port request; slv_add_i  in  NUM_PORTS*ADDR_W  address; slv_wen_i  in  NUM_PORTS  write-enable-low (1 = read); slv_wdata_i  in  NUM_PORTS*DATA_W  write data; slv_be_i  in  NUM_PORTS*BE_W  byte enables.
REQ-007 SHALL have slv_gnt_o  out  NUM_PORTS  grant; slv_r_valid_o  out  NUM_PORTS  response valid; slv_r_opc_o  out  NUM_PORTS  response error; slv_r_rdata_o  out  NUM_PORTS*DATA_W  read data.
REQ-008 SHALL have mst_req_o, mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o (out; widths 1, ADDR_W, 1, DATA_W, BE_W) and mst_gnt_i, mst_r_valid_i, mst_r_opc_i, mst_r_rdata_i (in; widths 1, 1, 1, DATA_W).

Function
REQ-009 SHALL select one requesting port sel per cycle; mst_req_o = (any slv_req_i) AND NOT full; mst_add/wen/wdata/be_o driven from port sel (port 0 when none requests).
REQ-010 SHALL assert slv_gnt_o[sel] = mst_gnt_i AND mst_req_o, all other grants 0; request-to-master and grant paths combinational (zero latency).
REQ-011 Handshake = mst_req_o AND mst_gnt_i; on handshake SHALL push sel into an in-order ID FIFO of depth MAX_OUT.
REQ-012 Lock: if mst_req_o high without mst_gnt_i, SHALL keep sel unchanged next cycle while that port's req stays high; lock releases on handshake or req drop.
REQ-013 On mst_r_valid_i with FIFO non-empty SHALL assert slv_r_valid_o[head] and slv_r_opc_o[head] = mst_r_opc_i, same cycle, then pop; other ports 0.
REQ-014 slv_r_rdata_o SHALL broadcast mst_r_rdata_i to all ports every cycle.
REQ-015 Full (count == MAX_OUT): mst_req_o = 0 and all slv_gnt_o = 0, even with a same-cycle pop (no r_valid-to-req path); issue resumes the cycle after count drops.
REQ-016 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers wrap modulo MAX_OUT.
REQ-017 mst_r_valid_i with empty FIFO SHALL be dropped: no slv_r_valid_o, count stays 0.
REQ-018 NUM_PORTS = 1 SHALL degenerate to pass-through with outstanding tracking; ID width = max(1, clog2(NUM_PORTS)).

Reset
REQ-019 While rst_i high SHALL force mst_req_o = 0, slv_gnt_o = 0, slv_r_valid_o = 0, slv_r_opc_o = 0.
REQ-020 On reset SHALL clear FIFO count/pointers, lock, and round-robin pointer to 0; transactions outstanding at reset are discarded and their later responses dropped per REQ-017.

Configuration
REQ-021 Macro TCDM_ARB_NX1_RR_EN defined: round-robin; search starts at rr_ptr, rr_ptr <= (sel+1) mod NUM_PORTS after each handshake.
REQ-022 Macro undefined: fixed priority, lowest requesting index wins, no rr_ptr register; lock (REQ-012) applies in both builds.

Verification
REQ-023 Ports 0,2 request, mst_gnt_i=1 constant, RR build -> grants alternate 0,2,0,2; fixed build -> port 0 granted every cycle.
REQ-024 Port 1 requests add=0x100, mst_gnt_i low 3 cycles then high, port 0 requests from cycle 1 -> mst_add_o stays 0x100 until gnt; port 1 granted first.
REQ-025 MAX_OUT=2, three back-to-back grants attempted, no r_valid -> third blocked (mst_req_o=0) until first r_valid; r_valid routed to ports in grant order.
REQ-026 Full FIFO, mst_r_valid_i and new req same cycle -> pop occurs, no grant that cycle, grant next cycle; push+pop later keeps count=1.
REQ-027 Reset asserted with 2 outstanding, then mst_r_valid_i=1, r_opc=1 after release -> no slv_r_valid_o, count 0, next request granted normally.

Source files
------------

// File: rtl/tcdm_arbiter_nx1.sv
// tcdm_arbiter_nx1: N-to-1 TCDM request arbiter with an in-order response router.
// Requests and grants pass combinationally between the selected slave port and the
// master port. Each accepted transaction records the winning port ID in a small FIFO,
// so that master responses can be routed back to their ports in order.
// Build option: define TCDM_ARB_NX1_RR_EN for round-robin arbitration. Without it the
// arbiter uses fixed priority, where the lowest requesting index wins.
module tcdm_arbiter_nx1 #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUT   = 2,
  localparam int unsigned BE_W     = DATA_W / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // slave side
  input  logic [NUM_PORTS-1:0]        slv_req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] slv_add_i,
  input  logic [NUM_PORTS-1:0]        slv_wen_i,
  input  logic [NUM_PORTS*DATA_W-1:0] slv_wdata_i,
  input  logic [NUM_PORTS*BE_W-1:0]   slv_be_i,
  output logic [NUM_PORTS-1:0]        slv_gnt_o,
  output logic [NUM_PORTS-1:0]        slv_r_valid_o,
  output logic [NUM_PORTS-1:0]        slv_r_opc_o,
  output logic [NUM_PORTS*DATA_W-1:0] slv_r_rdata_o,
  // master side
  output logic                        mst_req_o,
  output logic [ADDR_W-1:0]           mst_add_o,
  output logic                        mst_wen_o,
  output logic [DATA_W-1:0]           mst_wdata_o,
  output logic [BE_W-1:0]             mst_be_o,
  input  logic                        mst_gnt_i,
  input  logic                        mst_r_valid_i,
  input  logic                        mst_r_opc_i,
  input  logic [DATA_W-1:0]           mst_r_rdata_i
);

  localparam int unsigned IdW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  // Arbitration state
  logic           lock_q, lock_d;
  logic [IdW-1:0] lock_id_q, lock_id_d;
  logic [IdW-1:0] sel;
  logic           lock_hit;
  logic           found;
  logic           any_req;
`ifdef TCDM_ARB_NX1_RR_EN
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Outstanding-ID FIFO
  logic [IdW-1:0]  id_mem [MAX_OUT];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdW-1:0]  head;
  logic            full;
  logic            handshake;
  logic            pop;

  // Pointer advance that wraps at MAX_OUT, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(MAX_OUT - 1)) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  // Choose the port to serve: a locked port keeps priority while it keeps requesting.
  always_comb begin
    any_req  = |slv_req_i;
    lock_hit = 1'b0;
    found    = 1'b0;
    sel      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (lock_q && (IdW'(i) == lock_id_q) && slv_req_i[i]) begin
        lock_hit = 1'b1;
      end
    end
    if (lock_hit) begin
      sel = lock_id_q;
    end else begin
`ifdef TCDM_ARB_NX1_RR_EN
      // Search upward from rr_ptr, wrapping at NUM_PORTS.
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        int unsigned idx;
        idx = (32'(rr_ptr_q) + k) % NUM_PORTS;
        if (!found && slv_req_i[idx]) begin
          sel   = IdW'(idx);
          found = 1'b1;
        end
      end
`else
      // Lowest requesting index wins.
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (!found && slv_req_i[k]) begin
          sel   = IdW'(k);
          found = 1'b1;
        end
      end
`endif
    end
  end

  // Master request, handshake and FIFO pop qualification.
  always_comb begin
    full      = (count_q == CntW'(MAX_OUT));
    // full blocks issue even when a pop happens in the same cycle: no r_valid-to-req path.
    mst_req_o = !rst_i && any_req && !full;
    handshake = mst_req_o && mst_gnt_i;
    // Responses arriving with nothing outstanding are silently dropped.
    pop       = !rst_i && mst_r_valid_i && (count_q != '0);
    head      = id_mem[rd_ptr_q];
  end

  // Forward the selected port's payload (port 0 when nobody requests).
  always_comb begin
    mst_add_o   = slv_add_i[ADDR_W-1:0];
    mst_wen_o   = slv_wen_i[0];
    mst_wdata_o = slv_wdata_i[DATA_W-1:0];
    mst_be_o    = slv_be_i[BE_W-1:0];
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (IdW'(i) == sel) begin
        mst_add_o   = slv_add_i[i*ADDR_W +: ADDR_W];
        mst_wen_o   = slv_wen_i[i];
        mst_wdata_o = slv_wdata_i[i*DATA_W +: DATA_W];
        mst_be_o    = slv_be_i[i*BE_W +: BE_W];
      end
    end
  end

  // Per-port grant and response routing; read data is broadcast to every port.
  always_comb begin
    slv_gnt_o     = '0;
    slv_r_valid_o = '0;
    slv_r_opc_o   = '0;
    slv_r_rdata_o = {NUM_PORTS{mst_r_rdata_i}};
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (IdW'(i) == sel) begin
        slv_gnt_o[i] = handshake;
      end
      if (IdW'(i) == head) begin
        slv_r_valid_o[i] = pop;
        slv_r_opc_o[i]   = pop & mst_r_opc_i;
      end
    end
  end

  // Next-state for lock, round-robin pointer and FIFO bookkeeping.
  always_comb begin
    // A request left waiting for grant pins the selection for the next cycle.
    lock_d    = mst_req_o && !mst_gnt_i;
    lock_id_d = sel;
`ifdef TCDM_ARB_NX1_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d = (sel == IdW'(NUM_PORTS - 1)) ? '0 : sel + IdW'(1);
    end
`endif
    wr_ptr_d = handshake ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({handshake, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset; outstanding transactions are forgotten.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

`ifdef TCDM_ARB_NX1_RR_EN
  // Round-robin start pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // ID storage; contents are only meaningful below count_q, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      id_mem[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_tcdm_arbiter_nx1.sv
// tb_tcdm_arbiter_nx1: directed scenarios plus randomized traffic for tcdm_arbiter_nx1,
// checked against a transaction-level model (queue of outstanding port IDs).
// Follows the build macro TCDM_ARB_NX1_RR_EN in the same way as the design.
module tb_tcdm_arbiter_nx1;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   slv_req, slv_wen, slv_gnt, slv_r_valid, slv_r_opc;
  logic [NP*AW-1:0] slv_add;
  logic [NP*DW-1:0] slv_wdata, slv_r_rdata;
  logic [NP*BW-1:0] slv_be;
  logic            mst_req, mst_wen, mst_gnt, mst_r_valid, mst_r_opc;
  logic [AW-1:0]   mst_add;
  logic [DW-1:0]   mst_wdata, mst_r_rdata;
  logic [BW-1:0]   mst_be;

  int total = 0;
  int bad   = 0;

  // Model state
  int  oq[$];
  bit  lock_v;
  int  lock_p;
  int  rr;
  int  exp_sel;
  bit  exp_req, exp_hs, exp_pop;
  logic [NP-1:0] exp_gnt, exp_rvalid, exp_opc;
  logic [AW-1:0] exp_add;
  logic [DW-1:0] exp_wdata;
  logic [BW-1:0] exp_be;
  logic          exp_wen;

  tcdm_arbiter_nx1 #(
    .NUM_PORTS(NP),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_OUT  (MO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (slv_req),
    .slv_add_i    (slv_add),
    .slv_wen_i    (slv_wen),
    .slv_wdata_i  (slv_wdata),
    .slv_be_i     (slv_be),
    .slv_gnt_o    (slv_gnt),
    .slv_r_valid_o(slv_r_valid),
    .slv_r_opc_o  (slv_r_opc),
    .slv_r_rdata_o(slv_r_rdata),
    .mst_req_o    (mst_req),
    .mst_add_o    (mst_add),
    .mst_wen_o    (mst_wen),
    .mst_wdata_o  (mst_wdata),
    .mst_be_o     (mst_be),
    .mst_gnt_i    (mst_gnt),
    .mst_r_valid_i(mst_r_valid),
    .mst_r_opc_i  (mst_r_opc),
    .mst_r_rdata_i(mst_r_rdata)
  );

  always #5 clk = ~clk;

  // Expected combinational behaviour for the current inputs.
  task automatic model_eval();
    bit found;
    int s;
    found = 0;
    s     = 0;
    if (lock_v && slv_req[lock_p]) begin
      s     = lock_p;
      found = 1;
    end else begin
      for (int k = 0; k < NP; k++) begin
        int idx;
`ifdef TCDM_ARB_NX1_RR_EN
        idx = (rr + k) % NP;
`else
        idx = k;
`endif
        if (!found && slv_req[idx]) begin
          s     = idx;
          found = 1;
        end
      end
    end
    exp_sel    = s;
    exp_req    = !rst && found && (oq.size() < MO);
    exp_hs     = exp_req && mst_gnt;
    exp_gnt    = '0;
    if (exp_hs) exp_gnt[s] = 1'b1;
    exp_pop    = !rst && mst_r_valid && (oq.size() > 0);
    exp_rvalid = '0;
    exp_opc    = '0;
    if (exp_pop) begin
      exp_rvalid[oq[0]] = 1'b1;
      exp_opc[oq[0]]    = mst_r_opc;
    end
    exp_add   = slv_add[s*AW +: AW];
    exp_wen   = slv_wen[s];
    exp_wdata = slv_wdata[s*DW +: DW];
    exp_be    = slv_be[s*BW +: BW];
  endtask

  // State change at the clock edge.
  task automatic model_commit();
    if (rst) begin
      oq.delete();
      lock_v = 0;
      lock_p = 0;
      rr     = 0;
    end else begin
      if (exp_pop) void'(oq.pop_front());
      if (exp_hs) oq.push_back(exp_sel);
      lock_v = exp_req && !mst_gnt;
      lock_p = exp_sel;
      if (exp_hs) rr = (exp_sel + 1) % NP;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    slv_req     = '0;
    slv_wen     = '0;
    slv_add     = '0;
    slv_wdata   = '0;
    slv_be      = '0;
    mst_gnt     = 1'b0;
    mst_r_valid = 1'b0;
    mst_r_opc   = 1'b0;
    mst_r_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    settle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst         = 1'b1;
    slv_req     = 4'b1111;
    mst_gnt     = 1'b1;
    mst_r_valid = 1'b1;
    mst_r_opc   = 1'b1;
    mst_r_rdata = 32'hdead_beef;
    settle();
    total++;
    if (mst_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mst_req); end
    total++;
    if (slv_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", slv_gnt); end
    total++;
    if (slv_r_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_rvalid got=%b exp=0000", slv_r_valid);
    end
    total++;
    if (slv_r_opc !== 4'b0000) begin bad++; $display("FAIL reset_opc got=%b exp=0000", slv_r_opc); end
    total++;
    if (slv_r_rdata !== {NP{32'hdead_beef}}) begin
      bad++; $display("FAIL reset_rdata got=%h exp=%h", slv_r_rdata, {NP{32'hdead_beef}});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_priority();
    logic [NP-1:0] want;
    apply_reset();
    slv_req     = 4'b0101;
    mst_gnt     = 1'b1;
    mst_r_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
`ifdef TCDM_ARB_NX1_RR_EN
      want = (i % 2 == 1) ? 4'b0100 : 4'b0001;
`else
      want = 4'b0001;
`endif
      total++;
      if (slv_gnt !== want) begin
        bad++; $display("FAIL prio_gnt cyc=%0d got=%b exp=%b", i, slv_gnt, want);
      end
      total++;
      if (slv_gnt !== exp_gnt) begin
        bad++; $display("FAIL prio_model cyc=%0d got=%b exp=%b", i, slv_gnt, exp_gnt);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    apply_reset();
    slv_add[1*AW +: AW] = 32'h100;
    slv_add[0*AW +: AW] = 32'h200;
    slv_req = 4'b0010;
    mst_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) slv_req = 4'b0011;
      settle();
      total++;
      if (mst_add !== 32'h100) begin
        bad++; $display("FAIL lock_add cyc=%0d got=%h exp=00000100", i, mst_add);
      end
      total++;
      if (mst_req !== 1'b1 || slv_gnt !== 4'b0000) begin
        bad++; $display("FAIL lock_wait cyc=%0d got=%b/%b exp=1/0000", i, mst_req, slv_gnt);
      end
      tick();
    end
    mst_gnt = 1'b1;
    settle();
    total++;
    if (slv_gnt !== 4'b0010 || mst_add !== 32'h100) begin
      bad++; $display("FAIL lock_first got=%b/%h exp=0010/00000100", slv_gnt, mst_add);
    end
    tick();
    slv_req = 4'b0001;
    settle();
    total++;
    if (slv_gnt !== 4'b0001 || mst_add !== 32'h200) begin
      bad++; $display("FAIL lock_next got=%b/%h exp=0001/00000200", slv_gnt, mst_add);
    end
    tick();
  endtask

  task automatic test_full();
    logic [NP-1:0] reqs [8];
    logic          rvs  [8];
    logic [NP-1:0] wg   [8];
    logic [NP-1:0] wrv  [8];
    reqs = '{4'b1000, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    rvs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    wg   = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    wrv  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0001};
    apply_reset();
    mst_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req     = reqs[i];
      mst_r_valid = rvs[i];
      mst_r_opc   = rvs[i] && (i % 2 == 1);
      settle();
      total++;
      if (slv_gnt !== wg[i] || mst_req !== (wg[i] != 0)) begin
        bad++; $display("FAIL full_gnt cyc=%0d got=%b/%b exp=%b", i, slv_gnt, mst_req, wg[i]);
      end
      total++;
      if (slv_r_valid !== wrv[i] || slv_r_opc !== exp_opc) begin
        bad++;
        $display("FAIL full_rsp cyc=%0d got=%b/%b exp=%b/%b", i, slv_r_valid, slv_r_opc,
                 wrv[i], exp_opc);
      end
      tick();
    end
  endtask

  task automatic test_reset_outstanding();
    apply_reset();
    mst_gnt = 1'b1;
    slv_req = 4'b0001;
    settle();
    tick();
    slv_req = 4'b0010;
    settle();
    tick();
    slv_req = '0;
    rst     = 1'b1;
    settle();
    tick();
    rst         = 1'b0;
    mst_r_valid = 1'b1;
    mst_r_opc   = 1'b1;
    settle();
    total++;
    if (slv_r_valid !== 4'b0000 || slv_r_opc !== 4'b0000) begin
      bad++; $display("FAIL rstout_drop got=%b/%b exp=0000/0000", slv_r_valid, slv_r_opc);
    end
    tick();
    mst_r_valid = 1'b0;
    mst_r_opc   = 1'b0;
    slv_req     = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++;
      if (slv_gnt !== ((i < 2) ? 4'b0100 : 4'b0000) || mst_req !== (i < 2)) begin
        bad++; $display("FAIL rstout_gnt cyc=%0d got=%b/%b", i, slv_gnt, mst_req);
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      slv_req     = NP'($urandom);
      slv_wen     = NP'($urandom);
      mst_gnt     = ($urandom_range(0, 3) != 0);
      mst_r_valid = $urandom_range(0, 1);
      mst_r_opc   = $urandom_range(0, 1);
      mst_r_rdata = $urandom;
      for (int p = 0; p < NP; p++) begin
        slv_add[p*AW +: AW]   = $urandom;
        slv_wdata[p*DW +: DW] = $urandom;
        slv_be[p*BW +: BW]    = BW'($urandom);
      end
      settle();
      total++;
      if (mst_req !== exp_req || slv_gnt !== exp_gnt) begin
        bad++;
        $display("FAIL rnd_req cyc=%0d got=%b/%b exp=%b/%b", c, mst_req, slv_gnt, exp_req,
                 exp_gnt);
      end
      total++;
      if (slv_r_valid !== exp_rvalid || slv_r_opc !== exp_opc) begin
        bad++;
        $display("FAIL rnd_rsp cyc=%0d got=%b/%b exp=%b/%b", c, slv_r_valid, slv_r_opc,
                 exp_rvalid, exp_opc);
      end
      total++;
      if (slv_r_rdata !== {NP{mst_r_rdata}}) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, slv_r_rdata, {NP{mst_r_rdata}});
      end
      if (!rst) begin
        total++;
        if (mst_add !== exp_add || mst_wen !== exp_wen || mst_wdata !== exp_wdata ||
            mst_be !== exp_be) begin
          bad++;
          $display("FAIL rnd_payload cyc=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", c, mst_add,
                   mst_wen, mst_wdata, mst_be, exp_add, exp_wen, exp_wdata, exp_be);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    oq.delete();
    lock_v = 0;
    lock_p = 0;
    rr     = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_priority();
    test_lock();
    test_full();
    test_reset_outstanding();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
